// File: rtl/cacheline_arbiter.sv
// Shares one cacheline memory port between icache (read-only) and dcache (read/write).
// Tie policy: dcache wins by default; define ARB_ROUND_ROBIN_EN for round-robin ties.
//
// state   | meaning
// IDLE    | no transaction in flight, arbitrate live requests
// SERVE_I | icache line read owns the memory port
// SERVE_D | dcache line read or writeback owns the memory port
module cacheline_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   req_i, req_d;
  logic   tie_to_i;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // High when dcache completed the most recent transaction.
  logic last_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b1;
    end else if (mem_resp && state_q == SERVE_I) begin
      last_d_q <= 1'b0;
    end else if (mem_resp && state_q == SERVE_D) begin
      last_d_q <= 1'b1;
    end
  end

  assign tie_to_i = last_d_q;
`else
  assign tie_to_i = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          state_d = tie_to_i ? SERVE_I : SERVE_D;
        end else if (req_i) begin
          state_d = SERVE_I;
        end else if (req_d) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory side follows the live inputs of the granted requester; nothing is latched.
  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    case (state_q)
      SERVE_I: begin
        mem_addr = i_addr;
        mem_read = 1'b1;
      end
      SERVE_D: begin
        mem_addr  = d_addr;
        mem_read  = d_read & ~d_write;
        mem_write = d_write;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  assign i_resp  = (state_q == SERVE_I) & mem_resp;
  assign d_resp  = (state_q == SERVE_D) & mem_resp;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: directed scenarios then random traffic, every cycle
// checked against a transaction-level owner model.
module tb_cacheline_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic          i_read, i_resp, d_read, d_write, d_resp;
  logic          mem_read, mem_write, mem_resp;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

  cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int own   = 0;      // 0 none, 1 icache, 2 dcache
  bit last_d = 1'b1;
  int lat   = 0;
  bit i_done, d_done;
  int served_q[$];
  int served_t[$];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks all outputs mid-cycle, then advances the model at the edge.
  task automatic tick();
    logic [AW-1:0] e_addr;
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [LW-1:0] e_wd, e_ird, e_drd;
    @(negedge clk);
    e_addr = '0; e_rd = 1'b0; e_wr = 1'b0; e_wd = '0;
    e_ir = 1'b0; e_dr = 1'b0; e_ird = '0; e_drd = '0;
    if (own == 1) begin
      e_addr = i_addr; e_rd = 1'b1;
      e_ir = mem_resp; e_ird = mem_resp ? mem_rdata : '0;
    end else if (own == 2) begin
      e_addr = d_addr; e_wr = d_write; e_rd = d_read && !d_write; e_wd = d_wdata;
      e_dr = mem_resp; e_drd = mem_resp ? mem_rdata : '0;
    end
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("i_resp", i_resp, e_ir);
    chk("i_rdata", i_rdata, e_ird);
    chk("d_resp", d_resp, e_dr);
    chk("d_rdata", d_rdata, e_drd);
    @(posedge clk);
    i_done = 1'b0;
    d_done = 1'b0;
    if (rst) begin
      own = 0;
      last_d = 1'b1;
    end else if (own != 0) begin
      if (mem_resp) begin
        served_q.push_back(own);
        served_t.push_back(cyc);
        if (own == 1) i_done = 1'b1; else d_done = 1'b1;
        last_d = (own == 2);
        own = 0;
      end
    end else if (i_read && (d_read || d_write)) begin
`ifdef ARB_ROUND_ROBIN_EN
      own = last_d ? 1 : 2;
`else
      own = 2;
`endif
    end else if (i_read) begin
      own = 1;
    end else if (d_read || d_write) begin
      own = 2;
    end
    cyc++;
    #1;
  endtask

  // Requesters drop their level request once the completion pulse was seen.
  task automatic step();
    tick();
    if (i_done) i_read = 1'b0;
    if (d_done) begin d_read = 1'b0; d_write = 1'b0; end
  endtask

  task automatic rand_line(output logic [LW-1:0] v);
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
  endtask

  initial begin
    logic [LW-1:0] pat;
    int exp_order[$];
    rst = 1'b1; i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Lone icache read, memory answers in the third serve cycle.
    served_q.delete();
    i_read = 1'b1; i_addr = 32'h6000_0020; rand_line(mem_rdata);
    step();
    step(); step();
    mem_resp = 1'b1; rand_line(mem_rdata);
    step();
    mem_resp = 1'b0;
    step();
    chk("t1_count", served_q.size(), 1);
    if (served_q.size() > 0) chk("t1_side", served_q[0], 1);

    // Lone dcache writeback.
    served_q.delete();
    d_write = 1'b1; d_addr = 32'h0000_1000; d_wdata = {32{8'hA5}};
    step(); step();
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    step();
    chk("t2_count", served_q.size(), 1);
    if (served_q.size() > 0) chk("t2_side", served_q[0], 2);

    // Simultaneous requests from IDLE with minimum memory latency.
    served_q.delete(); served_t.delete();
    i_read = 1'b1; i_addr = 32'h0000_2000; d_read = 1'b1; d_addr = 32'h0000_3000;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 2, 1, 2};
`else
    exp_order = '{2, 1};
`endif
    for (int n = 0; n < 40 && served_q.size() < exp_order.size(); n++) begin
      tick();
`ifndef ARB_ROUND_ROBIN_EN
      if (i_done) i_read = 1'b0;
      if (d_done) d_read = 1'b0;
`endif
      rand_line(mem_rdata);
      mem_resp = (own != 0) && !mem_resp;
    end
    mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
    chk("t3_count", served_q.size(), exp_order.size());
    for (int k = 0; k < exp_order.size() && k < served_q.size(); k++) begin
      chk("t3_order", served_q[k], exp_order[k]);
      if (k > 0) chk("t3_gap", served_t[k] - served_t[k-1], 2);
    end
    step(); step();

    // Late competitor: dcache arrives one cycle into the icache grant.
    served_q.delete();
    i_read = 1'b1; i_addr = 32'h0000_4040;
    step();
    d_read = 1'b1; d_addr = 32'h0000_5080;
    step(); step();
    mem_resp = 1'b1; rand_line(mem_rdata);
    step();
    mem_resp = 1'b0;
    step(); step();
    mem_resp = 1'b1; rand_line(mem_rdata);
    step();
    mem_resp = 1'b0;
    step();
    chk("t4_count", served_q.size(), 2);
    if (served_q.size() == 2) begin
      chk("t4_first", served_q[0], 1);
      chk("t4_second", served_q[1], 2);
    end

    // Stray mem_resp in IDLE, then a response while icache is served.
    served_q.delete();
    mem_resp = 1'b1; rand_line(mem_rdata);
    step(); step();
    mem_resp = 1'b0;
    step();
    chk("t5_stray", served_q.size(), 0);
    i_read = 1'b1; i_addr = 32'h0000_6000;
    step();
    mem_resp = 1'b1; rand_line(mem_rdata);
    step();
    mem_resp = 1'b0;
    step();

    // Reset during SERVE_D abandons the transaction; held request is re-granted.
    served_q.delete();
    d_read = 1'b1; d_addr = 32'h0000_7000;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step();
    mem_resp = 1'b1; rand_line(mem_rdata);
    step();
    mem_resp = 1'b0;
    step();
    chk("t6_regrant", served_q.size(), 1);

    // Random traffic with variable latency, stray responses and occasional reset.
    lat = 0;
    for (int n = 0; n < 2000; n++) begin
      step();
      if (!i_read && $urandom_range(0, 3) == 0) begin
        i_read = 1'b1;
        i_addr = $urandom() & 32'hFFFF_FFE0;
      end
      if (!d_read && !d_write && $urandom_range(0, 3) == 0) begin
        d_addr = $urandom() & 32'hFFFF_FFE0;
        rand_line(d_wdata);
        case ($urandom_range(0, 2))
          0: d_read = 1'b1;
          1: d_write = 1'b1;
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
      end
      rand_line(mem_rdata);
      if (own != 0) begin
        if (lat == 0) lat = $urandom_range(1, 4);
        lat--;
        mem_resp = (lat == 0);
      end else begin
        lat = 0;
        mem_resp = ($urandom_range(0, 9) == 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      if (rst) lat = 0;
    end
    rst = 1'b0; mem_resp = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
